// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard / forwarding unit.
// Entries store register numbers at the widest legal address width, so a single
// typedef serves every REG_AW. Narrower addresses are zero-extended on entry.
package hazard_pkg;

  localparam int MAX_AW = 6;
  localparam int FWD_RF = 0;
  localparam logic [MAX_AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic              valid;
    logic [MAX_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } prod_entry_t;

  typedef struct packed {
    logic              valid;
    logic [MAX_AW-1:0] rs;
    logic [MAX_AW-1:0] rt;
    logic              uses_rs;
    logic              uses_rt;
    logic [MAX_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } ex_entry_t;

  function automatic logic params_ok(int aw, int depth, int lat);
    return (aw >= 3) && (aw <= 6) && (depth >= 2) && (depth <= 4) &&
           (lat >= 1) && (lat <= depth - 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// fwd_match: picks the youngest producer stage that can supply one EX operand.
// A load is eligible only once it has travelled LOAD_LAT stages past EX.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int SW       = 2
) (
  input  logic [MAX_AW-1:0]       src,
  input  logic                    uses,
  input  prod_entry_t [DEPTH:1]   prod,
  output logic [SW-1:0]           sel
);

  // Scan from oldest to youngest so the youngest eligible match is the one left in sel.
  always_comb begin
    sel = SW'(FWD_RF);
    for (int k = DEPTH; k >= 1; k--) begin
      if (uses && prod[k].valid && prod[k].reg_write &&
          (prod[k].rd == src) && (src != ZERO_REG) &&
          (!prod[k].mem_read || (k >= 1 + LOAD_LAT))) begin
        sel = SW'(k);
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: tracks the EX stage and FWD_DEPTH producer stages, selects
// EX operand forwarding, and generates load-use / branch stalls and redirect flushes.
// Optional macro HAZ_PERF_CNT_EN adds stall_cycles and flush_count counters.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ext_stall,
  input  logic                             id_valid,
  input  logic [REG_AW-1:0]                id_rs,
  input  logic [REG_AW-1:0]                id_rt,
  input  logic                             id_uses_rs,
  input  logic                             id_uses_rt,
  input  logic [REG_AW-1:0]                id_rd,
  input  logic                             id_reg_write,
  input  logic                             id_mem_read,
  input  logic                             id_branch,
  input  logic                             id_redirect,
  output logic                             pc_load,
  output logic                             ifid_load,
  output logic                             ifid_flush,
  output logic                             idex_bubble,
  output logic [$clog2(FWD_DEPTH+1)-1:0]   fwd_a,
  output logic [$clog2(FWD_DEPTH+1)-1:0]   fwd_b
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]                      stall_cycles,
  output logic [31:0]                      flush_count
`endif
);

  localparam int SW = $clog2(FWD_DEPTH + 1);

  if (!params_ok(REG_AW, FWD_DEPTH, LOAD_LAT)) begin : g_param_err
    $error("hazard_fwd_unit: illegal REG_AW / FWD_DEPTH / LOAD_LAT combination");
  end

  ex_entry_t                   ex_q;
  ex_entry_t                   ex_next;
  prod_entry_t [FWD_DEPTH:1]   prod_q;
  logic [MAX_AW-1:0]           rs_x;
  logic [MAX_AW-1:0]           rt_x;
  logic                        rs_hot;
  logic                        rt_hot;
  logic                        load_use;
  logic                        branch_haz;
  logic                        hazard_stall;

  assign rs_x   = MAX_AW'(id_rs);
  assign rt_x   = MAX_AW'(id_rt);
  assign rs_hot = id_valid && id_uses_rs && (rs_x != ZERO_REG);
  assign rt_hot = id_valid && id_uses_rt && (rt_x != ZERO_REG);

  // Compare ID sources against in-flight loads that are not yet forwardable, and
  // against any pending writer a branch in ID would need to compare early.
  always_comb begin
    load_use   = 1'b0;
    branch_haz = 1'b0;
    if (ex_q.valid && ex_q.mem_read &&
        ((rs_hot && ex_q.rd == rs_x) || (rt_hot && ex_q.rd == rt_x))) begin
      load_use = 1'b1;
    end
    for (int p = 1; p < LOAD_LAT; p++) begin
      if (prod_q[p].valid && prod_q[p].mem_read &&
          ((rs_hot && prod_q[p].rd == rs_x) || (rt_hot && prod_q[p].rd == rt_x))) begin
        load_use = 1'b1;
      end
    end
    if (id_branch) begin
      if (ex_q.valid && ex_q.reg_write &&
          ((rs_hot && ex_q.rd == rs_x) || (rt_hot && ex_q.rd == rt_x))) begin
        branch_haz = 1'b1;
      end
      for (int p = 1; p < FWD_DEPTH; p++) begin
        if (prod_q[p].valid && prod_q[p].reg_write &&
            ((rs_hot && prod_q[p].rd == rs_x) || (rt_hot && prod_q[p].rd == rt_x))) begin
          branch_haz = 1'b1;
        end
      end
    end
  end

  assign hazard_stall = load_use || branch_haz;

  // Pipeline control: reset forces a free-running pipe, then ext_stall, stall, flush in priority order.
  always_comb begin
    pc_load     = 1'b1;
    ifid_load   = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (rst) begin
      pc_load = 1'b1;
    end else if (ext_stall) begin
      pc_load   = 1'b0;
      ifid_load = 1'b0;
    end else if (hazard_stall) begin
      pc_load     = 1'b0;
      ifid_load   = 1'b0;
      idex_bubble = 1'b1;
    end else if (id_redirect && id_valid) begin
      ifid_flush = 1'b1;
    end
  end

  // Next EX entry: the ID instruction, or an invalid bubble when ID is empty or stalled.
  always_comb begin
    ex_next = '0;
    if (id_valid && !hazard_stall) begin
      ex_next.valid     = 1'b1;
      ex_next.rs        = rs_x;
      ex_next.rt        = rt_x;
      ex_next.uses_rs   = id_uses_rs;
      ex_next.uses_rt   = id_uses_rt;
      ex_next.rd        = MAX_AW'(id_rd);
      ex_next.reg_write = id_reg_write;
      ex_next.mem_read  = id_mem_read;
    end
  end

  // Advance the EX and producer shift chain unless the whole pipe is frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q   <= '0;
      prod_q <= '0;
    end else if (!ext_stall) begin
      prod_q[1] <= '{valid: ex_q.valid, rd: ex_q.rd,
                     reg_write: ex_q.reg_write, mem_read: ex_q.mem_read};
      for (int k = 2; k <= FWD_DEPTH; k++) begin
        prod_q[k] <= prod_q[k-1];
      end
      ex_q <= ex_next;
    end
  end

  fwd_match #(.DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT), .SW(SW)) u_match_a (
    .src  (ex_q.rs),
    .uses (ex_q.uses_rs),
    .prod (prod_q),
    .sel  (fwd_a)
  );

  fwd_match #(.DEPTH(FWD_DEPTH), .LOAD_LAT(LOAD_LAT), .SW(SW)) u_match_b (
    .src  (ex_q.rt),
    .uses (ex_q.uses_rt),
    .prod (prod_q),
    .sel  (fwd_b)
  );

`ifdef HAZ_PERF_CNT_EN
  // Count hazard stall cycles (frozen cycles excluded) and issued flushes; both wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!ext_stall && hazard_stall) stall_cycles <= stall_cycles + 32'd1;
      if (ifid_flush)                 flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule
